// File: rtl/branch_predictor_gshare_pkg.sv
// Shared constants for the gshare next-PC predictor: mode codes and
// 2-bit direction counter encodings.
package branch_predictor_gshare_pkg;

    typedef logic [1:0] mode_t;
    typedef logic [1:0] cnt_t;

    // Direction policy selected by the MODE parameter.
    localparam mode_t MODE_NT   = 2'd0;  // always not taken
    localparam mode_t MODE_AT   = 2'd1;  // taken whenever the BTB hits
    localparam mode_t MODE_SAT  = 2'd2;  // 2-bit saturating counter
    localparam mode_t MODE_HYST = 2'd3;  // 2-bit hysteresis counter

    // Counter encodings; bit 1 is the predicted direction.
    localparam cnt_t CNT_SNT = 2'b00;
    localparam cnt_t CNT_WNT = 2'b01;
    localparam cnt_t CNT_WT  = 2'b10;
    localparam cnt_t CNT_ST  = 2'b11;

    // True when a counter state predicts taken.
    function automatic logic cnt_taken(input cnt_t c);
        return c[1];
    endfunction

endpackage

// File: rtl/branch_predictor_gshare_if.sv
// Pipeline-facing bundle of the predictor: IF lookup, ID install, EX resolve
// and the statistics counters. The predictor sits on the slave side.
interface branch_predictor_gshare_if #(
    parameter int WORD_SIZE    = 16,
    parameter int BTB_IDX_SIZE = 8
);
    // IF lookup
    logic [WORD_SIZE-1:0]    pc_if;
    logic [WORD_SIZE-1:0]    pred_pc_if;
    logic                    pred_taken_if;
    logic [BTB_IDX_SIZE-1:0] pred_idx_if;
    // ID target install
    logic                    tag_upd_valid;
    logic [WORD_SIZE-1:0]    tag_upd_pc;
    logic [WORD_SIZE-1:0]    tag_upd_target;
    // EX resolve
    logic                    resolve_valid;
    logic [BTB_IDX_SIZE-1:0] resolve_idx;
    logic                    resolve_taken;
    logic [WORD_SIZE-1:0]    resolve_pred_pc;
    logic [WORD_SIZE-1:0]    resolve_actual_pc;
    logic                    resolve_miss;
    // statistics
    logic [WORD_SIZE-1:0]    num_branch;
    logic [WORD_SIZE-1:0]    num_branch_miss;

    modport slave (
        input  pc_if, tag_upd_valid, tag_upd_pc, tag_upd_target,
               resolve_valid, resolve_idx, resolve_taken,
               resolve_pred_pc, resolve_actual_pc,
        output pred_pc_if, pred_taken_if, pred_idx_if,
               resolve_miss, num_branch, num_branch_miss
    );

    modport master (
        output pc_if, tag_upd_valid, tag_upd_pc, tag_upd_target,
               resolve_valid, resolve_idx, resolve_taken,
               resolve_pred_pc, resolve_actual_pc,
        input  pred_pc_if, pred_taken_if, pred_idx_if,
               resolve_miss, num_branch, num_branch_miss
    );

endinterface

// File: rtl/branch_predictor_gshare_counter_next.sv
// Next-state function of one 2-bit direction counter. Pure combinational;
// policies without a counter pass the state through unchanged.
module bp_counter_next
    import branch_predictor_gshare_pkg::*;
(
    input  mode_t mode,
    input  cnt_t  cnt,
    input  logic  taken,
    output cnt_t  cnt_next
);

    // Apply the selected training policy to the current counter state.
    always_comb begin
        cnt_next = cnt;
        case (mode)
            MODE_SAT: begin
                if (taken) cnt_next = (cnt == CNT_ST)  ? CNT_ST  : cnt + 2'd1;
                else       cnt_next = (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
            end
            MODE_HYST: begin
                // Weak states jump to the strong state of the observed
                // direction, except that SNT only relaxes to WNT on taken.
                if (taken) cnt_next = (cnt == CNT_SNT) ? CNT_WNT : CNT_ST;
                else       cnt_next = (cnt == CNT_ST)  ? CNT_WT  : CNT_SNT;
            end
            default: cnt_next = cnt;
        endcase
    end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Next-PC predictor: tagged direct-mapped BTB plus a BHT of 2-bit counters,
// optionally indexed with global history (gshare). Lookup is combinational;
// installs, training, history and statistics take effect on the next edge.
module branch_predictor_gshare
    import branch_predictor_gshare_pkg::*;
#(
    parameter int WORD_SIZE    = 16,
    parameter int BTB_IDX_SIZE = 8,
    parameter int MODE         = 2,
    parameter int GHR_LEN      = 0
) (
    input logic                      clk,
    input logic                      reset,
    branch_predictor_gshare_if.slave bp
);

    localparam int W     = WORD_SIZE;
    localparam int IDX   = BTB_IDX_SIZE;
    localparam int TAG_W = W - IDX;
    localparam int N     = 1 << IDX;
    localparam int GL    = (GHR_LEN > 0) ? GHR_LEN : 1;
    localparam mode_t MODE_C = mode_t'(MODE);
    localparam bit TRAIN = (MODE_C == MODE_SAT) || (MODE_C == MODE_HYST);

    // tables
    logic             btb_valid  [N];
    logic [TAG_W-1:0] btb_tag    [N];
    logic [W-1:0]     btb_target [N];
    cnt_t             bht        [N];
    logic [GL-1:0]    ghr;

    // lookup
    logic [IDX-1:0] bidx;
    logic [IDX-1:0] hidx;
    logic           hit;
    logic           taken;
    logic [IDX-1:0] uidx;
    cnt_t           cnt_next;
    logic           miss;

    assign bidx = bp.pc_if[IDX-1:0];
    assign hit  = btb_valid[bidx] && (btb_tag[bidx] == bp.pc_if[W-1:IDX]);
    assign hidx = (GHR_LEN > 0) ? (bp.pc_if[IDX-1:0] ^ IDX'(ghr)) : bp.pc_if[IDX-1:0];
    assign uidx = bp.tag_upd_pc[IDX-1:0];
    assign miss = bp.resolve_valid && (bp.resolve_pred_pc != bp.resolve_actual_pc);

    // Direction decision for the fetched PC under the configured policy.
    always_comb begin
        taken = 1'b0;
        case (MODE_C)
            MODE_NT:  taken = 1'b0;
            MODE_AT:  taken = hit;
            default:  taken = hit && cnt_taken(bht[hidx]);
        endcase
    end

    assign bp.pred_taken_if = taken;
    assign bp.pred_idx_if   = hidx;
    assign bp.pred_pc_if    = taken ? btb_target[bidx] : bp.pc_if + W'(1);
    assign bp.resolve_miss  = miss;

    bp_counter_next u_cnt_next (
        .mode     (MODE_C),
        .cnt      (bht[bp.resolve_idx]),
        .taken    (bp.resolve_taken),
        .cnt_next (cnt_next)
    );

    // Valid bits and BHT: cleared in one cycle on reset, then install/train.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                btb_valid[i] <= 1'b0;
                bht[i]       <= CNT_WNT;
            end
        end else begin
            if (bp.tag_upd_valid) btb_valid[uidx] <= 1'b1;
            if (TRAIN && bp.resolve_valid) bht[bp.resolve_idx] <= cnt_next;
        end
    end

    // Tag and target payload; only meaningful behind a set valid bit.
    always_ff @(posedge clk) begin
        if (!reset && bp.tag_upd_valid) begin
            btb_tag[uidx]    <= bp.tag_upd_pc[W-1:IDX];
            btb_target[uidx] <= bp.tag_upd_target;
        end
    end

    // Global history shifts in resolved directions (non-speculative).
    generate
        if (GHR_LEN > 1) begin : g_ghr
            always_ff @(posedge clk) begin
                if (reset) ghr <= '0;
                else if (TRAIN && bp.resolve_valid) ghr <= {ghr[GL-2:0], bp.resolve_taken};
            end
        end else if (GHR_LEN == 1) begin : g_ghr1
            always_ff @(posedge clk) begin
                if (reset) ghr <= '0;
                else if (TRAIN && bp.resolve_valid) ghr <= bp.resolve_taken;
            end
        end else begin : g_no_ghr
            assign ghr = '0;
        end
    endgenerate

    // Saturating resolved-branch and mispredict counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            bp.num_branch      <= '0;
            bp.num_branch_miss <= '0;
        end else if (bp.resolve_valid) begin
            if (bp.num_branch != '1) bp.num_branch <= bp.num_branch + W'(1);
            if (miss && bp.num_branch_miss != '1) bp.num_branch_miss <= bp.num_branch_miss + W'(1);
        end
    end

endmodule
